// File: rtl/button_press_classifier.sv
// Purpose: two-button front end; sync, debounce and classify each press as short or long, stretched for slow samplers.
// Latency: 2 sync + DB_CYCLES to debounced level, +1 to classify; long asserts LONG_CYCLES after debounced press.
// Backpressure: none; outputs are free-running registered levels, consumers just sample them.
module button_press_classifier #(
    parameter int DB_CYCLES   = 1000000,
    parameter int LONG_CYCLES = 100000000,
    parameter int HOLD_CYCLES = 100000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn0,
    input  logic btn1,
    output logic b0short,
    output logic b0long,
    output logic b1short,
    output logic b1long
);
    localparam int DW = $clog2(DB_CYCLES + 1);
    localparam int PW = $clog2(LONG_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, PRESS, LONG} state_t;

    logic [1:0] raw;
    logic [1:0] short_flag;
    logic [1:0] long_flag;

    assign raw     = {btn1, btn0};
    assign b0short = short_flag[0];
    assign b0long  = long_flag[0];
    assign b1short = short_flag[1];
    assign b1long  = long_flag[1];

    // One fully independent channel per button; nothing is shared between them.
    for (genvar g = 0; g < 2; g++) begin : g_chan
        logic          sync1;
        logic          sync2;
        logic          db;
        logic [DW-1:0] db_cnt;
        state_t        state;
        state_t        state_nxt;
        logic [PW-1:0] press_cnt;
        logic [PW-1:0] press_cnt_nxt;
        logic          short_evt;
        logic          long_rel;
        logic [HW-1:0] short_cnt;
        logic [HW-1:0] long_cnt;
        logic          short_q;
        logic          long_q;

        // Two-flop synchroniser for the asynchronous raw button.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
            end else begin
                sync1 <= raw[g];
                sync2 <= sync1;
            end
        end

        // Debounce: flip only after DB_CYCLES consecutive disagreeing samples.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                db     <= 1'b0;
                db_cnt <= '0;
            end else if (sync2 == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DB_CYCLES - 1)) begin
                db     <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end

        // Press classifier state and duration counter.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= IDLE;
                press_cnt <= '0;
            end else begin
                state     <= state_nxt;
                press_cnt <= press_cnt_nxt;
            end
        end

        // Next state; press counter stops at LONG_CYCLES-1 so it can never wrap.
        always_comb begin
            state_nxt     = state;
            press_cnt_nxt = press_cnt;
            short_evt     = 1'b0;
            long_rel      = 1'b0;
            case (state)
                IDLE: begin
                    if (db) begin
                        state_nxt     = PRESS;
                        press_cnt_nxt = '0;
                    end
                end
                PRESS: begin
                    if (!db) begin
                        state_nxt = IDLE;
                        short_evt = 1'b1;
                    end else if (press_cnt == PW'(LONG_CYCLES - 1)) begin
                        state_nxt = LONG;
                    end else begin
                        press_cnt_nxt = press_cnt + 1'b1;
                    end
                end
                LONG: begin
                    if (!db) begin
                        state_nxt = IDLE;
                        long_rel  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Short flag stretch; a new short event reloads the counter so back-to-back presses merge.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                short_cnt <= '0;
                short_q   <= 1'b0;
            end else if (short_evt) begin
                short_cnt <= HW'(HOLD_CYCLES);
                short_q   <= 1'b1;
            end else if (short_cnt != '0) begin
                short_cnt <= short_cnt - 1'b1;
                short_q   <= (short_cnt != HW'(1));
            end
        end

        // Long flag: high while in LONG, then extended after release; a new press does not cancel the tail.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                long_cnt <= '0;
                long_q   <= 1'b0;
            end else if (state_nxt == LONG) begin
                long_cnt <= '0;
                long_q   <= 1'b1;
            end else if (long_rel) begin
                long_cnt <= HW'(HOLD_CYCLES);
                long_q   <= 1'b1;
            end else if (long_cnt != '0) begin
                long_cnt <= long_cnt - 1'b1;
                long_q   <= (long_cnt != HW'(1));
            end
        end

        assign short_flag[g] = short_q;
        assign long_flag[g]  = long_q;
    end

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with DB=4, LONG=20, HOLD=8.
// Index i in a run is the i-th rising edge after inputs are set; edge 0 captures the first input value.
// Outputs are sampled 1 ns after each rising edge and recorded into per-output history vectors.
module tb_button_press_classifier;
    localparam int DB   = 4;
    localparam int LG   = 20;
    localparam int HD   = 8;
    localparam int MAXN = 128;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic btn0 = 1'b0;
    logic btn1 = 1'b0;
    logic b0short, b0long, b1short, b1long;

    int errors = 0;
    int checks = 0;

    logic [MAXN-1:0] h0s, h0l, h1s, h1l;

    always #5 clk = ~clk;

    button_press_classifier #(
        .DB_CYCLES  (DB),
        .LONG_CYCLES(LG),
        .HOLD_CYCLES(HD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .btn0   (btn0),
        .btn1   (btn1),
        .b0short(b0short),
        .b0long (b0long),
        .b1short(b1short),
        .b1long (b1long)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int first1(input logic [MAXN-1:0] v, input int n);
        for (int i = 0; i < n; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int last1(input logic [MAXN-1:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    function automatic int cnt1(input logic [MAXN-1:0] v, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) if (v[i]) c++;
        return c;
    endfunction

    // btn0 high for edges [a_on,a_off); btn1 high for [b_on,b_off) and [c_on,c_off).
    task automatic run(input int n, input int a_on, input int a_off,
                       input int b_on, input int b_off, input int c_on, input int c_off);
        h0s = '0; h0l = '0; h1s = '0; h1l = '0;
        for (int i = 0; i < n; i++) begin
            btn0 = (i >= a_on && i < a_off);
            btn1 = (i >= b_on && i < b_off) || (i >= c_on && i < c_off);
            @(posedge clk);
            #1;
            h0s[i] = b0short;
            h0l[i] = b0long;
            h1s[i] = b1short;
            h1l[i] = b1long;
        end
        btn0 = 1'b0;
        btn1 = 1'b0;
    endtask

    task automatic do_reset();
        btn0 = 1'b0;
        btn1 = 1'b0;
        rst  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: outputs clear, and stay clear with buttons held during reset.
        #2 rst = 1'b1;
        #1;
        check("reset_outputs", int'({b0short, b0long, b1short, b1long}), 0);
        btn0 = 1'b1;
        btn1 = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("reset_held_outputs", int'({b0short, b0long, b1short, b1long}), 0);
        btn0 = 1'b0;
        btn1 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Glitch: 3-edge pulse is shorter than the debounce window.
        run(30, 0, 3, 0, 0, 0, 0);
        check("glitch_b0short", cnt1(h0s, 30), 0);
        check("glitch_b0long", cnt1(h0l, 30), 0);
        do_reset();

        // Short: btn1 high 10 edges. Debounced fall at 15, classified at 16, stretched 8.
        run(40, 0, 0, 0, 10, 0, 0);
        check("short_first", first1(h1s, 40), 16);
        check("short_count", cnt1(h1s, 40), HD);
        check("short_last", last1(h1s, 40), 16 + HD - 1);
        check("short_b1long", cnt1(h1l, 40), 0);
        check("short_b0_quiet", cnt1(h0s | h0l, 40), 0);
        do_reset();

        // Long: btn0 held 40 edges. Rise at 2+4+20=26; release classified at 40+6=46, tail of 8.
        run(70, 0, 40, 0, 0, 0, 0);
        check("long_first", first1(h0l, 70), 2 + DB + LG);
        check("long_last", last1(h0l, 70), 46 + HD - 1);
        check("long_count", cnt1(h0l, 70), 46 + HD - 26);
        check("long_no_short", cnt1(h0s, 70), 0);
        do_reset();

        // Combo: b0 long 26..73, b1 short press at 35 gives short 51..58: full 8-cycle overlap.
        run(100, 0, 60, 35, 45, 0, 0);
        check("combo_overlap", cnt1(h0l & h1s, 100), HD);
        check("combo_b1short_first", first1(h1s, 100), 35 + 16);
        check("combo_b1long", cnt1(h1l, 100), 0);
        check("combo_b0short", cnt1(h0s, 100), 0);
        do_reset();

        // Reload: tightest back-to-back presses the debounce allows (4 high, 4 low, 4 high).
        // Short events at 10 and 18; second reloads at the last cycle of the first stretch -> 10..25.
        run(40, 0, 0, 0, 4, 8, 12);
        check("reload_first", first1(h1s, 40), 10);
        check("reload_count", cnt1(h1s, 40), 8 + HD);
        check("reload_last", last1(h1s, 40), 18 + HD - 1);
        check("reload_b1long", cnt1(h1l, 40), 0);
        do_reset();

        // Reset mid-long: b0long is high at edge 29, async reset clears it at once.
        run(30, 0, 30, 0, 0, 0, 0);
        btn0 = 1'b1;
        check("rml_long_before", int'(h0l[29]), 1);
        #2 rst = 1'b1;
        #1;
        check("rml_long_in_reset", int'(b0long), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        // Still-held button is a fresh press from the first edge after reset release.
        run(40, 0, 40, 0, 0, 0, 0);
        check("rml_long_refirst", first1(h0l, 40), 2 + DB + LG);
        check("rml_no_short", cnt1(h0s, 40), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
